// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and Wishbone-style bus signals of the load/store unit.
interface load_store_unit_if;
    logic        I_req;
    logic        I_we;
    logic [2:0]  I_funct3;
    logic [31:0] I_addr;
    logic [31:0] I_wdata;
    logic        O_busy;
    logic        O_done;
    logic [31:0] O_rdata;
    logic        O_exc;
    logic [1:0]  O_exc_cause;
    logic        O_bus_cyc;
    logic        O_bus_stb;
    logic        O_bus_we;
    logic [3:0]  O_bus_sel;
    logic [31:0] O_bus_addr;
    logic [31:0] O_bus_wdata;
    logic        I_bus_ack;
    logic [31:0] I_bus_rdata;

    // The load/store unit is the bus master.
    modport master (
        input  I_req, I_we, I_funct3, I_addr, I_wdata, I_bus_ack, I_bus_rdata,
        output O_busy, O_done, O_rdata, O_exc, O_exc_cause,
        output O_bus_cyc, O_bus_stb, O_bus_we, O_bus_sel, O_bus_addr, O_bus_wdata
    );

    // Surrounding pipeline plus memory slave.
    modport slave (
        output I_req, I_we, I_funct3, I_addr, I_wdata, I_bus_ack, I_bus_rdata,
        input  O_busy, O_done, O_rdata, O_exc, O_exc_cause,
        input  O_bus_cyc, O_bus_stb, O_bus_we, O_bus_sel, O_bus_addr, O_bus_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: single-beat bus transaction with byte-lane steering,
// load extension, fault classification and bus timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              I_clk,
    input  logic              I_rst,
    load_store_unit_if.master lsu
);
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  sz, a;
    logic        illegal, misaligned, accept, fault, ack_hit, tmo_hit;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    logic        cyc_q, we_q, done_q, exc_q;
    logic [1:0]  cause_q, a_q;
    logic [2:0]  f3_q;
    logic [3:0]  sel_q;
    logic [31:0] addr_q, wdata_q, rdata_q, cnt_q;

    // Classify the incoming request: illegal funct3 takes priority over misalignment.
    always_comb begin
        sz = lsu.I_funct3[1:0];
        a  = lsu.I_addr[1:0];
        if (lsu.I_we)
            illegal = lsu.I_funct3[2] | (sz == 2'b11);
        else
            illegal = (sz == 2'b11) | (lsu.I_funct3[2] & sz[1]);
        misaligned = ((sz == 2'b01) & a[0]) | ((sz == 2'b10) & (a != 2'b00));
        accept = (state == ST_IDLE) & lsu.I_req & ~illegal & ~misaligned;
        fault  = (state == ST_IDLE) & lsu.I_req & (illegal | misaligned);
    end

    // Byte-lane enables and lane-replicated store data for the request.
    always_comb begin
        case (sz)
            2'b00: begin
                sel_d   = 4'b0001 << a;
                wdata_d = {4{lsu.I_wdata[7:0]}};
            end
            2'b01: begin
                sel_d   = a[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{lsu.I_wdata[15:0]}};
            end
            default: begin
                sel_d   = '1;
                wdata_d = lsu.I_wdata;
            end
        endcase
    end

    // Extract and extend load data from the slave using the registered request.
    always_comb begin
        ld_byte = lsu.I_bus_rdata[{a_q, 3'b000} +: 8];
        ld_half = a_q[1] ? lsu.I_bus_rdata[31:16] : lsu.I_bus_rdata[15:0];
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'b0, ld_byte};
            3'b101:  ld_val = {16'b0, ld_half};
            default: ld_val = lsu.I_bus_rdata;
        endcase
    end

    // WAIT exit conditions; an ack in the timeout cycle wins.
    always_comb begin
        ack_hit = (state == ST_WAIT) & lsu.I_bus_ack;
        tmo_hit = (state == ST_WAIT) & ~lsu.I_bus_ack & (TIMEOUT_CYCLES != 0)
                  & (cnt_q == TIMEOUT_CYCLES - 1);
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_WAIT;
            ST_WAIT: if (ack_hit || tmo_hit) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge I_clk) begin
        if (I_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Bus fields, response pulses, load data and timeout counter.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            a_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            exc_q   <= 1'b0;
            cause_q <= '0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            exc_q  <= 1'b0;
            if (fault) begin
                exc_q   <= 1'b1;
                cause_q <= illegal ? 2'b10 : 2'b01;
            end
            if (accept) begin
                cyc_q   <= 1'b1;
                we_q    <= lsu.I_we;
                sel_q   <= sel_d;
                addr_q  <= {lsu.I_addr[31:2], 2'b00};
                wdata_q <= wdata_d;
                f3_q    <= lsu.I_funct3;
                a_q     <= lsu.I_addr[1:0];
                cnt_q   <= '0;
            end
            if (ack_hit) begin
                cyc_q  <= 1'b0;
                done_q <= 1'b1;
                if (!we_q) rdata_q <= ld_val;
            end else if (tmo_hit) begin
                cyc_q   <= 1'b0;
                exc_q   <= 1'b1;
                cause_q <= 2'b11;
            end else if (state == ST_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign lsu.O_busy      = accept | (state == ST_WAIT);
    assign lsu.O_done      = done_q;
    assign lsu.O_rdata     = rdata_q;
    assign lsu.O_exc       = exc_q;
    assign lsu.O_exc_cause = cause_q;
    assign lsu.O_bus_cyc   = cyc_q;
    assign lsu.O_bus_stb   = cyc_q;
    assign lsu.O_bus_we    = we_q;
    assign lsu.O_bus_sel   = sel_q;
    assign lsu.O_bus_addr  = addr_q;
    assign lsu.O_bus_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a behavioural reference model.
module tb_load_store_unit;
    localparam int unsigned TMO = 4;

    logic I_clk = 1'b0;
    logic I_rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] m_rdata = '0;
    logic [1:0]  m_cause = '0;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .I_clk (I_clk),
        .I_rst (I_rst),
        .lsu   (bus)
    );

    always #5 I_clk = ~I_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference load value computed from the byte/half/word rules.
    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [31:0] v;
        case (f3[1:0])
            2'b00:   v = (d >> (int'(a) * 8)) & 32'hFF;
            2'b01:   v = (d >> (int'(a[1]) * 16)) & 32'hFFFF;
            default: v = d;
        endcase
        if (f3 == 3'b000 && v >= 32'd128)   v = v - 32'd256;
        if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    task automatic idle_cycle();
        @(negedge I_clk);
        check("idle_done", bus.O_done, 1'b0);
        check("idle_exc", bus.O_exc, 1'b0);
        check("idle_busy", bus.O_busy, 1'b0);
    endtask

    // One access, entered and left at a negedge. ackd 0..TMO-1: ack in WAIT cycle ackd+1;
    // ackd >= TMO: no ack, timeout expected.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] srd, input int unsigned ackd);
        int unsigned nbytes, nwait;
        logic        legal_f3, mis, acks;
        logic [3:0]  sel_e;
        logic [31:0] wd_e;
        nbytes   = 32'd1 << f3[1:0];
        legal_f3 = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis      = (addr % nbytes) != 0;
        sel_e    = 4'(((32'd1 << nbytes) - 1) << addr[1:0]);
        case (nbytes)
            1:       wd_e = (wd & 32'hFF) * 32'h01010101;
            2:       wd_e = (wd & 32'hFFFF) * 32'h00010001;
            default: wd_e = wd;
        endcase
        acks  = ackd < TMO;
        nwait = acks ? ackd + 1 : TMO;

        bus.I_req = 1'b1; bus.I_we = we; bus.I_funct3 = f3;
        bus.I_addr = addr; bus.I_wdata = wd; bus.I_bus_ack = 1'b0;
        #1;
        check("busy_req", bus.O_busy, legal_f3 && !mis);
        if (!legal_f3 || mis) begin
            @(negedge I_clk);
            bus.I_req = 1'b0;
            m_cause = !legal_f3 ? 2'b10 : 2'b01;
            check("fault_exc", bus.O_exc, 1'b1);
            check("fault_done", bus.O_done, 1'b0);
            check("fault_cyc", bus.O_bus_cyc, 1'b0);
        end else begin
            for (int unsigned k = 1; k <= nwait; k++) begin
                @(negedge I_clk);
                check("wait_cyc", bus.O_bus_cyc, 1'b1);
                check("wait_stb", bus.O_bus_stb, 1'b1);
                check("wait_busy", bus.O_busy, 1'b1);
                check("wait_done", bus.O_done, 1'b0);
                check("wait_exc", bus.O_exc, 1'b0);
                check("bus_addr", bus.O_bus_addr, addr & ~32'h3);
                check("bus_sel", bus.O_bus_sel, sel_e);
                check("bus_we", bus.O_bus_we, we);
                if (we) check("bus_wdata", bus.O_bus_wdata, wd_e);
                if (k == nwait) bus.I_req = 1'b0;
                if (acks && k == nwait) begin
                    bus.I_bus_ack = 1'b1; bus.I_bus_rdata = srd;
                end else begin
                    bus.I_bus_ack = 1'b0; bus.I_bus_rdata = $urandom;
                end
            end
            @(negedge I_clk);
            bus.I_bus_ack = 1'b0;
            check("end_cyc", bus.O_bus_cyc, 1'b0);
            check("end_busy", bus.O_busy, 1'b0);
            if (acks) begin
                if (!we) m_rdata = load_val(f3, addr[1:0], srd);
                check("done", bus.O_done, 1'b1);
                check("done_exc", bus.O_exc, 1'b0);
            end else begin
                m_cause = 2'b11;
                check("tmo_exc", bus.O_exc, 1'b1);
                check("tmo_done", bus.O_done, 1'b0);
            end
        end
        check("rdata", bus.O_rdata, m_rdata);
        check("cause", bus.O_exc_cause, m_cause);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"}, bus.O_bus_cyc, 1'b0);
        check({tag, "_stb"}, bus.O_bus_stb, 1'b0);
        check({tag, "_we"}, bus.O_bus_we, 1'b0);
        check({tag, "_sel"}, bus.O_bus_sel, 4'h0);
        check({tag, "_addr"}, bus.O_bus_addr, 32'h0);
        check({tag, "_wdata"}, bus.O_bus_wdata, 32'h0);
        check({tag, "_done"}, bus.O_done, 1'b0);
        check({tag, "_exc"}, bus.O_exc, 1'b0);
        check({tag, "_cause"}, bus.O_exc_cause, 2'b00);
        check({tag, "_rdata"}, bus.O_rdata, 32'h0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.I_req = 1'b0; bus.I_we = 1'b0; bus.I_funct3 = '0; bus.I_addr = '0;
        bus.I_wdata = '0; bus.I_bus_ack = 1'b0; bus.I_bus_rdata = '0;
        repeat (3) @(negedge I_clk);
        check_all_zero("reset");
        I_rst = 1'b0;

        // Word load, byte/half loads (back-to-back), stores.
        access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        idle_cycle();
        access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80112233, 1);
        access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0);
        access(1'b0, 3'b101, 32'h202, 32'h0, 32'h80112233, 0);
        access(1'b0, 3'b001, 32'h202, 32'h0, 32'h80112233, 0);
        access(1'b1, 3'b000, 32'h41, 32'h000000A5, 32'h0, 1);
        access(1'b1, 3'b001, 32'h42, 32'h00001234, 32'h0, 0);
        idle_cycle();

        // Faults: misaligned word, illegal load funct3, illegal store funct3.
        access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
        idle_cycle();
        access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        access(1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        idle_cycle();

        // Timeout, then ack on the last allowed WAIT cycle.
        access(1'b0, 3'b010, 32'h500, 32'h0, 32'h0, TMO);
        idle_cycle();
        access(1'b0, 3'b010, 32'h504, 32'h0, 32'hCAFEF00D, TMO - 1);
        idle_cycle();

        // Reset in the second WAIT cycle, ack one cycle later.
        bus.I_req = 1'b1; bus.I_we = 1'b0; bus.I_funct3 = 3'b010; bus.I_addr = 32'h300;
        @(negedge I_clk);
        check("rst_wait_cyc", bus.O_bus_cyc, 1'b1);
        @(negedge I_clk);
        I_rst = 1'b1;
        @(negedge I_clk);
        I_rst = 1'b0; bus.I_req = 1'b0; bus.I_bus_ack = 1'b1; bus.I_bus_rdata = 32'h12345678;
        m_rdata = '0; m_cause = '0;
        #1;
        check("rst_busy", bus.O_busy, 1'b0);
        check_all_zero("rst_edge");
        @(negedge I_clk);
        bus.I_bus_ack = 1'b0;
        check_all_zero("rst_after_ack");

        // Randomized accesses against the model.
        for (int i = 0; i < 60; i++) begin
            access(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                   $urandom_range(0, TMO));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
